// File: rtl/apb_reg_slave.sv
// -----------------------------------------------------------------------------
// apb_reg_slave
//   APB4 completer fronting a bank of NUM_REGS word-aligned registers with
//   byte-strobe writes, WAIT_CYCLES programmable wait states and error
//   response. The register contents are exported as a flat vector.
//
//   Optional feature macro: APB_REG_SLAVE_PROT_CHECK_EN
//     defined   -> unprivileged writes (pprot_i[0]=0) are rejected with
//                  pslverr_o and do not commit
//     undefined -> pprot_i is ignored
//
// Ports:
//   clk_i      clock
//   rst_ni     synchronous active-low reset
//   paddr_i    byte address
//   pprot_i    protection attributes
//   psel_i     select
//   penable_i  access phase
//   pwrite_i   1 = write
//   pwdata_i   write data
//   pstrb_i    byte write strobes
//   pready_o   transfer complete (registered, single-cycle pulse)
//   prdata_o   read data (registered, 0 unless completing a good read)
//   pslverr_o  error response (registered)
//   reg_q_o    register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]
// -----------------------------------------------------------------------------
module apb_reg_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [ADDR_WIDTH-1:0]          paddr_i,
  input  logic [2:0]                     pprot_i,
  input  logic                           psel_i,
  input  logic                           penable_i,
  input  logic                           pwrite_i,
  input  logic [DATA_WIDTH-1:0]          pwdata_i,
  input  logic [DATA_WIDTH/8-1:0]        pstrb_i,
  output logic                           pready_o,
  output logic [DATA_WIDTH-1:0]          prdata_o,
  output logic                           pslverr_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int AL     = (STRB_W > 1) ? $clog2(STRB_W) : 0;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << AL) - 64'd1);
  localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
  localparam logic [3:0]            WAIT_LOAD  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_r, state_next_s;
  logic [3:0]            cnt_r, cnt_next_s;
  logic [IDX_W-1:0]      idx_r;
  logic                  err_r;
  logic                  write_r;
  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
  logic                  pready_r, pslverr_r;
  logic [DATA_WIDTH-1:0] prdata_r;

  logic [ADDR_WIDTH-1:0] word_idx_s;
  logic                  setup_s;
  logic                  dec_err_s;
  logic                  prot_err_s;
  logic [IDX_W-1:0]      sel_idx_s;
  logic                  sel_err_s;
  logic                  sel_wr_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic                  unused_prot_s;

`ifdef APB_REG_SLAVE_PROT_CHECK_EN
  assign prot_err_s    = pwrite_i & ~pprot_i[0];
  assign unused_prot_s = ^pprot_i[2:1];
`else
  assign prot_err_s    = 1'b0;
  assign unused_prot_s = ^pprot_i;
`endif

  assign setup_s    = psel_i & ~penable_i;
  assign word_idx_s = paddr_i >> AL;

  // Address decode of the live bus: range, alignment and protection errors.
  always_comb begin
    dec_err_s = (word_idx_s >= NUM_REGS_A) | (|(paddr_i & ALIGN_MASK)) | prot_err_s;
  end

  // In IDLE the response for a zero-wait transfer is built from the live
  // decode (it is latched on the same edge); otherwise the latched decode rules.
  always_comb begin
    if (state_r == IDLE) begin
      sel_idx_s = word_idx_s[IDX_W-1:0];
      sel_err_s = dec_err_s;
      sel_wr_s  = pwrite_i;
    end else begin
      sel_idx_s = idx_r;
      sel_err_s = err_r;
      sel_wr_s  = write_r;
    end
  end

  // Read mux over the register bank; out-of-range indices yield zero.
  always_comb begin
    rd_word_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_word_s = (sel_idx_s == IDX_W'(i)) ? regs_r[i] : rd_word_s;
    end
  end

  // Next-state and wait-counter logic. The counter ends the access phase on
  // reaching 1 so that the registered pready lands on the last access cycle.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (setup_s) begin
          cnt_next_s   = WAIT_LOAD;
          state_next_s = (WAIT_LOAD == 4'd0) ? DONE : WAIT;
        end else begin
          cnt_next_s   = 4'd0;
        end
      end
      WAIT: begin
        if (!psel_i) begin
          state_next_s = IDLE;
          cnt_next_s   = 4'd0;
        end else if (penable_i) begin
          if (cnt_r <= 4'd1) begin
            state_next_s = DONE;
            cnt_next_s   = 4'd0;
          end else begin
            cnt_next_s   = cnt_r - 4'd1;
          end
        end else begin
          cnt_next_s   = cnt_r;
        end
      end
      DONE: begin
        state_next_s = IDLE;
        cnt_next_s   = 4'd0;
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // FSM state, wait counter, setup-phase decode latch and registered response.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      idx_r     <= {IDX_W{1'b0}};
      err_r     <= 1'b0;
      write_r   <= 1'b0;
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      prdata_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      if (state_r == IDLE && setup_s) begin
        idx_r   <= word_idx_s[IDX_W-1:0];
        err_r   <= dec_err_s;
        write_r <= pwrite_i;
      end
      pready_r  <= (state_next_s == DONE);
      pslverr_r <= (state_next_s == DONE) & sel_err_s;
      prdata_r  <= ((state_next_s == DONE) && !sel_err_s && !sel_wr_s)
                   ? rd_word_s : {DATA_WIDTH{1'b0}};
    end
  end

  // Register bank: byte-strobed commit in the completing cycle of a good write.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (state_r == DONE && write_r && !err_r) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (pstrb_i[b]) begin
          regs_r[idx_r][b*8 +: 8] <= pwdata_i[b*8 +: 8];
        end
      end
    end
  end

  genvar g;
  for (g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_r[g];
  end

  assign pready_o  = pready_r;
  assign pslverr_o = pslverr_r;
  assign prdata_o  = prdata_r;

endmodule

// File: doc/apb_reg_slave.md
# apb_reg_slave

APB4 completer that terminates the APB `Slave` modport. It decodes a word-aligned register bank of `NUM_REGS` registers, each `DATA_WIDTH` wide, with byte-strobe writes, optional programmable wait states and error response. It sits behind an APB interconnect and exposes the register contents as a flat vector to the surrounding datapath.

## Interface
- `ADDR_WIDTH`, 32, APB address width.
- `DATA_WIDTH`, 32, APB data width; must be a multiple of 8.
- `NUM_REGS`, 8, number of registers; ≥1.
- `WAIT_CYCLES`, 0, extra access-phase cycles before `pready_o`; 0..15.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: synchronous reset, active-low.
- `paddr_i` in `ADDR_WIDTH`: byte address.
- `pprot_i` in 3: protection attributes (APB `prot_t`).
- `psel_i` in 1: select.
- `penable_i` in 1: access phase.
- `pwrite_i` in 1: 1 = write.
- `pwdata_i` in `DATA_WIDTH`: write data.
- `pstrb_i` in `DATA_WIDTH/8`: byte write strobes.
- `pready_o` out 1: transfer complete.
- `prdata_o` out `DATA_WIDTH`: read data.
- `pslverr_o` out 1: error response.
- `reg_q_o` out `NUM_REGS*DATA_WIDTH`: register contents. Register *i* is at bits [*i*·DW +: DW].

## Operation
- Word index: `paddr_i >> log2(DATA_WIDTH/8)`.
- A transfer is in error if any of the following holds:
  - the word index is ≥ `NUM_REGS`;
  - the low `log2(DATA_WIDTH/8)` address bits are nonzero (misaligned);
  - it is a prot violation (see Configuration).
- FSM states:
  - `IDLE`: on `psel_i & !penable_i` (setup), latch the address decode and error flag, load the wait counter with `WAIT_CYCLES`, and go to `WAIT`.
  - `WAIT`: while `psel_i & penable_i`, decrement the counter. When the counter is 0, assert registered `pready_o`, `prdata_o` and `pslverr_o` for exactly the next cycle, then go to `DONE`. If `psel_i` drops, return to `IDLE` without a response or commit.
  - `DONE`: one cycle with `pready_o` high; the transfer completes here. Return to `IDLE`; a back-to-back setup is accepted in the following cycle.
- Write commit happens in the `DONE` cycle when `pwrite_i` is set and there is no error. For each byte *b* with `pstrb_i[b]=1`, the register byte takes `pwdata_i` byte *b*. The update is visible on `reg_q_o` the next cycle.
- Read:
  - `prdata_o` = selected register during `DONE` when there is no error; 0 otherwise.
  - `prdata_o` is 0 whenever `pready_o` is 0.
  - Reads ignore `pstrb_i`.
- Error:
  - `pslverr_o` = 1 only in `DONE` for an erroring transfer.
  - No register changes.
  - `prdata_o` = 0.
- Address/control changing between setup and access phases is a protocol violation. The decode latched at setup governs.

## Timing
- Reset (`rst_ni`=0 at a rising edge): FSM→`IDLE`, `pready_o`=0, `prdata_o`=0, `pslverr_o`=0, all registers and `reg_q_o`=0, counter=0.
- Reset asserted mid-transfer aborts it: no commit, and no `pready_o` after reset release.
- Access-phase length is `WAIT_CYCLES`+1 cycles. With `WAIT_CYCLES`=0: setup at cycle T, access at T+1 with `pready_o`=1.
- Setup at T → `pready_o` at cycle T+1+`WAIT_CYCLES`. The register update is visible at T+2+`WAIT_CYCLES`.
- `pready_o` is never high for two consecutive cycles.
- The counter is sized to 4 bits; it never wraps because it is reloaded every setup.

## Configuration
- `APB_REG_SLAVE_PROT_CHECK_EN`:
  - Defined: a write with `pprot_i[0]`=0 (unprivileged) is an error. `pslverr_o`=1 and no commit. Unprivileged reads are allowed.
  - Undefined: `pprot_i` is ignored, the port remains, and no prot errors are generated.

## Test plan
- Reset, then read reg 0 at address 0x0 with `WAIT_CYCLES`=0 → `pready_o` at setup+1, `prdata_o`=0x0, `pslverr_o`=0.
- Write 0xDEADBEEF to 0x4 with strb 0xF, then write 0x00001200 with strb 0x2 → read of 0x4 returns 0xDEAD12EF; `reg_q_o[63:32]`=0xDEAD12EF.
- `WAIT_CYCLES`=3, write to 0x8 → `pready_o` asserts exactly 4 access cycles after setup, for one cycle; the register updates the cycle after.
- Write to 0x20 (out of range, `NUM_REGS`=8) and to 0x2 (misaligned) → `pslverr_o`=1 with `pready_o`, `prdata_o`=0, all registers unchanged.
- With `APB_REG_SLAVE_PROT_CHECK_EN`, write 0x55 to 0x0 with `pprot_i`=3'b000 → `pslverr_o`=1, reg 0 unchanged. With `pprot_i`=3'b001 → reg 0=0x55.
- Assert `rst_ni`=0 during `WAIT` of a write (`WAIT_CYCLES`=2) → no `pready_o`, all registers 0, and the next transfer completes normally.
